// File: rtl/scan_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl_if
// Function : Request/response and scan-chain signal bundle for scan_chain_ctrl
// Revision : 1.0
// ============================================================================
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 START;
    logic                 ABORT;
    logic [CHAIN_LEN-1:0] PAT_IN;
    logic                 SO;
    logic                 TE;
    logic                 TI;
    logic                 BUSY;
    logic                 DONE;
    logic [CHAIN_LEN-1:0] RESP;

    // Test control logic together with the scan chain itself
    modport master (
        output START, ABORT, PAT_IN, SO,
        input  TE, TI, BUSY, DONE, RESP
    );

    // The sequencer
    modport slave (
        input  START, ABORT, PAT_IN, SO,
        output TE, TI, BUSY, DONE, RESP
    );
endinterface
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Function : Load / capture / unload sequencer for one muxed-D scan chain
// Revision : 1.0
// ============================================================================
module scan_chain_ctrl #(
    parameter int CHAIN_LEN  = 8,
    parameter int CAP_CYCLES = 1
) (
    input  wire logic         CP,
    input  wire logic         CD,
    scan_chain_ctrl_if.slave  bus
);
    localparam int MAX_LEN = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] C_SHIFT_INIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] C_CAP_INIT   = CNT_W'(CAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ZERO   = '0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_pat;
    logic [CHAIN_LEN-1:0] r_resp;
    logic                 r_te;
    logic                 r_ti;
    logic                 r_busy;
    logic                 r_done;

    logic w_accept;
    logic w_abort_run;
    logic w_cnt_zero;

    // FIN accepts a new request too, so back-to-back sequences lose no cycle
    assign w_accept    = bus.START && !bus.ABORT &&
                         ((r_state == S_IDLE) || (r_state == S_FIN));
    assign w_abort_run = bus.ABORT &&
                         ((r_state == S_LOAD) || (r_state == S_CAPTURE) ||
                          (r_state == S_UNLOAD));
    assign w_cnt_zero  = (r_cnt == C_CNT_ZERO);

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_resp  <= '0;
            r_te    <= 1'b0;
            r_ti    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort_run) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_te    <= 1'b0;
                r_ti    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_FIN: begin
                        if (w_accept) begin
                            r_state <= S_LOAD;
                            r_cnt   <= C_SHIFT_INIT;
                            r_pat   <= bus.PAT_IN;
                            r_resp  <= '0;
                            r_te    <= 1'b1;
                            r_ti    <= bus.PAT_IN[CHAIN_LEN-1];
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_te    <= 1'b0;
                            r_ti    <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end

                    S_LOAD: begin
                        if (w_cnt_zero) begin
                            r_state <= S_CAPTURE;
                            r_cnt   <= C_CAP_INIT;
                            r_te    <= 1'b0;
                            r_ti    <= 1'b0;
                        end else begin
                            // MSB first: the next bit out is always the one below the top
                            r_cnt <= r_cnt - 1'b1;
                            r_ti  <= r_pat[CHAIN_LEN-2];
                            r_pat <= {r_pat[CHAIN_LEN-2:0], 1'b0};
                        end
                    end

                    S_CAPTURE: begin
                        if (w_cnt_zero) begin
                            r_state <= S_UNLOAD;
                            r_cnt   <= C_SHIFT_INIT;
                            r_te    <= 1'b1;
                            r_ti    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end

                    S_UNLOAD: begin
                        // Counter equals CHAIN_LEN-1-j in unload cycle j, i.e. the RESP index
                        for (int i = 0; i < CHAIN_LEN; i++) begin
                            if (r_cnt == CNT_W'(i)) begin
                                r_resp[i] <= bus.SO;
                            end
                        end
                        if (w_cnt_zero) begin
                            r_state <= S_FIN;
                            r_te    <= 1'b0;
                            r_ti    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_te    <= 1'b0;
                        r_ti    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.TE   = r_te;
    assign bus.TI   = r_ti;
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;
    assign bus.RESP = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// Directed bench: three sequencers driving modelled 8-cell chains
// (inverting with 1 and 2 capture cycles, and a non-inverting one).

module tb_scan_chain_ctrl;
    logic CP;
    logic CD;
    int   tests = 0;
    int   fails = 0;
    int   dcount;

    scan_chain_ctrl_if #(.CHAIN_LEN(8)) ifa ();
    scan_chain_ctrl_if #(.CHAIN_LEN(8)) ifb ();
    scan_chain_ctrl_if #(.CHAIN_LEN(8)) ifc ();

    scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) dut_a (.CP(CP), .CD(CD), .bus(ifa));
    scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(2)) dut_b (.CP(CP), .CD(CD), .bus(ifb));
    scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) dut_c (.CP(CP), .CD(CD), .bus(ifc));

    logic [7:0] cha;
    logic [7:0] chb;
    logic [7:0] chc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chain models: A and B capture D = ~Q, C captures D = Q
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            cha <= '0;
            chb <= '0;
            chc <= '0;
        end else begin
            cha <= ifa.TE ? {cha[6:0], ifa.TI} : ~cha;
            chb <= ifb.TE ? {chb[6:0], ifb.TI} : ~chb;
            chc <= ifc.TE ? {chc[6:0], ifc.TI} : chc;
        end
    end

    assign ifa.SO = cha[7];
    assign ifb.SO = chb[7];
    assign ifc.SO = chc[7];

    initial CP = 1'b0;
    always #5 CP = ~CP;

    initial begin
        CD = 1'b0;
        ifa.START = 0; ifa.ABORT = 0; ifa.PAT_IN = '0;
        ifb.START = 0; ifb.ABORT = 0; ifb.PAT_IN = '0;
        ifc.START = 0; ifc.ABORT = 0; ifc.PAT_IN = '0;
        repeat (2) @(negedge CP);
        check("rst_te",   ifa.TE,   1'b0);
        check("rst_ti",   ifa.TI,   1'b0);
        check("rst_busy", ifa.BUSY, 1'b0);
        check("rst_done", ifa.DONE, 1'b0);
        check("rst_resp", ifa.RESP, 8'h00);
        CD = 1'b1;
        @(negedge CP);

        // START together with ABORT in IDLE is dropped
        ifa.PAT_IN = 8'hA5; ifa.START = 1; ifa.ABORT = 1;
        @(negedge CP);
        ifa.START = 0; ifa.ABORT = 0;
        check("sa_busy", ifa.BUSY, 1'b0);
        check("sa_te",   ifa.TE,   1'b0);
        @(negedge CP);
        check("sa_busy2", ifa.BUSY, 1'b0);

        // Basic, multi-capture and shift-ordering runs side by side
        ifa.PAT_IN = 8'hA5; ifa.START = 1;
        ifb.PAT_IN = 8'h3C; ifb.START = 1;
        ifc.PAT_IN = 8'h01; ifc.START = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CP);
            if (k == 1) begin
                ifa.START = 0; ifb.START = 0; ifc.START = 0;
            end
            check("a_te",   ifa.TE,   ((k <= 8) || (k >= 10 && k <= 17)));
            check("a_busy", ifa.BUSY, (k <= 17));
            check("a_done", ifa.DONE, (k == 18));
            check("b_te",   ifb.TE,   ((k <= 8) || (k >= 11 && k <= 18)));
            check("b_busy", ifb.BUSY, (k <= 18));
            check("b_done", ifb.DONE, (k == 19));
            if (k <= 8) check("c_ti", ifc.TI, (k == 8));
            if (k == 9) begin
                check("a_loaded", cha, 8'hA5);
                check("c_loaded", chc, 8'h01);
            end
            if (k == 18) begin
                check("a_resp", ifa.RESP, 8'h5A);
                check("c_resp", ifc.RESP, 8'h01);
                check("c_done", ifc.DONE, 1'b1);
            end
            if (k == 19) check("b_resp", ifb.RESP, 8'h3C);
            if (k == 20) check("a_resp_hold", ifa.RESP, 8'h5A);
        end

        // START ignored mid-run, then back-to-back START during FIN
        dcount = 0;
        ifa.PAT_IN = 8'hA5; ifa.START = 1;
        for (int k = 1; k <= 37; k++) begin
            @(negedge CP);
            ifa.START = 0;
            if (ifa.DONE) dcount++;
            if (k == 1) check("ig_resp_clr", ifa.RESP, 8'h00);
            if (k == 5) begin
                ifa.PAT_IN = 8'hFF; ifa.START = 1;
            end
            if (k == 18) begin
                check("ig_done", ifa.DONE, 1'b1);
                check("ig_resp", ifa.RESP, 8'h5A);
                ifa.PAT_IN = 8'h3C; ifa.START = 1;
            end
            if (k == 19) begin
                check("b2b_te",   ifa.TE,   1'b1);
                check("b2b_busy", ifa.BUSY, 1'b1);
                check("b2b_done", ifa.DONE, 1'b0);
            end
            if (k == 36) begin
                check("b2b_done2", ifa.DONE, 1'b1);
                check("b2b_resp",  ifa.RESP, 8'hC3);
            end
            if (k == 37) check("b2b_idle", ifa.BUSY, 1'b0);
        end
        check("ig_dcount", dcount, 2);

        // ABORT during unload
        dcount = 0;
        ifa.PAT_IN = 8'hA5; ifa.START = 1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge CP);
            ifa.START = 0;
            if (ifa.DONE) dcount++;
            if (k == 12) ifa.ABORT = 1;
            if (k == 13) begin
                ifa.ABORT = 0;
                check("ab_te",   ifa.TE,   1'b0);
                check("ab_busy", ifa.BUSY, 1'b0);
                check("ab_resp", ifa.RESP, 8'h40);
            end
        end
        check("ab_nodone", dcount, 0);
        ifa.PAT_IN = 8'hA5; ifa.START = 1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge CP);
            ifa.START = 0;
            if (k == 18) begin
                check("ab2_done", ifa.DONE, 1'b1);
                check("ab2_resp", ifa.RESP, 8'h5A);
            end
        end

        // Asynchronous reset in the middle of load
        @(negedge CP);
        ifa.PAT_IN = 8'hA5; ifa.START = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CP);
            ifa.START = 0;
        end
        check("cd_pre_te", ifa.TE, 1'b1);
        CD = 1'b0;
        #1;
        check("cd_te",   ifa.TE,   1'b0);
        check("cd_ti",   ifa.TI,   1'b0);
        check("cd_busy", ifa.BUSY, 1'b0);
        check("cd_done", ifa.DONE, 1'b0);
        check("cd_resp", ifa.RESP, 8'h00);
        @(negedge CP);
        CD = 1'b1;
        @(negedge CP);
        ifa.PAT_IN = 8'hA5; ifa.START = 1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge CP);
            ifa.START = 0;
            if (k == 1) check("cd2_busy", ifa.BUSY, 1'b1);
            if (k == 18) begin
                check("cd2_done", ifa.DONE, 1'b1);
                check("cd2_resp", ifa.RESP, 8'h5A);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
